// File: rtl/ramb_arb_pkg.sv
// Shared constants for the four-way single-port RAM arbiter.
// The file holds state encodings, requester count, RAM address width and the grant decision record.
package ramb_arb_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ISSUE = 2'b01;
  localparam logic [1:0] RESP  = 2'b10;

  localparam int NREQ = 4;
  localparam int AW   = 12;
  localparam int HW   = 4;

  // Result of one IDLE-state arbitration: who wins, and whether it was by lock.
  typedef struct packed {
    logic [1:0] idx;
    logic       locked;
  } pick_t;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/ramb_arb_rr_pick4.sv
// Round-robin picker: the first requester found when scanning from PRI upward, modulo 4.
module rr_pick4 (
  input  logic [3:0] REQ,
  input  logic [1:0] PRI,
  output logic [1:0] WIN,
  output logic       VALID
);

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] off;

  always_comb begin
    // After rotation, bit k of req_rot corresponds to requester PRI+k.
    req_dbl = {REQ, REQ} >> PRI;
    req_rot = req_dbl[3:0];
    off     = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) off = 2'(k);
    end
    WIN   = PRI + off;
    VALID = |REQ;
  end

endmodule

// File: rtl/ramb_arb.sv
// Arbitrates four requesters onto one single-port RAM using round-robin with bounded bus locking.
// Each access takes three cycles: the grant in IDLE, the RAM drive in ISSUE, and the ACK in RESP.
module ramb_arb
  import ramb_arb_pkg::*;
#(
  parameter int W       = 8,
  parameter int MAXHOLD = 4
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [NREQ-1:0]     REQ,
  input  logic [NREQ-1:0]     LOCK,
  input  logic [NREQ-1:0]     WE_IN,
  input  logic [NREQ*AW-1:0]  ADDR_IN,
  input  logic [NREQ*W-1:0]   D_IN,
  output logic [NREQ-1:0]     GNT,
  output logic [NREQ-1:0]     ACK,
  output logic [W-1:0]        Q_OUT,
  output logic                RAM_EN,
  output logic                RAM_WE,
  output logic [AW-1:0]       RAM_ADDR,
  output logic [W-1:0]        RAM_D,
  input  logic [W-1:0]        RAM_Q,
  output logic                BUSY
);

  localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);

  logic [1:0]      state_reg, state_next;
  logic [1:0]      owner_reg, owner_next;
  logic [1:0]      pri_reg, pri_next;
  logic [HW-1:0]   hold_reg, hold_next;
  logic            lock_reg, lock_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;

  logic [1:0]      rr_win;
  logic            rr_valid;
  pick_t           pick;
  logic            in_issue;

  logic [AW-1:0]   addr_slice [NREQ];
  logic [W-1:0]    data_slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign addr_slice[gi] = ADDR_IN[AW*gi +: AW];
      assign data_slice[gi] = D_IN[W*gi +: W];
    end
  endgenerate

  rr_pick4 u_pick (
    .REQ   (REQ),
    .PRI   (pri_reg),
    .WIN   (rr_win),
    .VALID (rr_valid)
  );

  // The previous owner keeps the bus only while its lock stands and the hold budget remains.
  always_comb begin
    pick.locked = lock_reg && REQ[owner_reg] && (hold_reg < HOLD_MAX);
    pick.idx    = pick.locked ? owner_reg : rr_win;
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    pri_next   = pri_reg;
    hold_next  = hold_reg;
    lock_next  = lock_reg;
    gnt_next   = gnt_reg;
    case (state_reg)
      IDLE: begin
        if (rr_valid) begin
          state_next = ISSUE;
          owner_next = pick.idx;
          gnt_next   = onehot4(pick.idx);
          if (pick.locked) begin
            hold_next = hold_reg + HW'(1);
          end else begin
            hold_next = '0;
            pri_next  = rr_win + 2'd1;
          end
        end
      end
      ISSUE: begin
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        lock_next  = LOCK[owner_reg];
        gnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_reg <= IDLE;
      owner_reg <= 2'd0;
      pri_reg   <= 2'd0;
      hold_reg  <= '0;
      lock_reg  <= 1'b0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      pri_reg   <= pri_next;
      hold_reg  <= hold_next;
      lock_reg  <= lock_next;
      gnt_reg   <= gnt_next;
    end
  end

  assign in_issue = (state_reg == ISSUE);
  assign RAM_EN   = in_issue;
  assign RAM_WE   = in_issue & WE_IN[owner_reg];
  assign RAM_ADDR = in_issue ? addr_slice[owner_reg] : '0;
  assign RAM_D    = in_issue ? data_slice[owner_reg] : '0;

  assign GNT   = gnt_reg;
  assign ACK   = (state_reg == RESP) ? onehot4(owner_reg) : '0;
  assign Q_OUT = (|ACK) ? RAM_Q : '0;
  assign BUSY  = (state_reg != IDLE);

endmodule

// File: doc/ramb_arb.md
RAMB_ARB -- requirements
Module: ramb_arb

Interface
REQ-001 Parameter W, default 8, data width of shared RAM port and of each requester data bus.
REQ-002 Parameter MAXHOLD, default 4, maximum consecutive grants one locked requester may hold, range 1..15.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 CLR  input  1  reset, asynchronous, active-high.
REQ-005 REQ  input  4  per-requester access request, level, held until its ACK.
REQ-006 LOCK  input  4  per-requester bus-lock hint, sampled in RESP for the owner only.
REQ-007 WE_IN  input  4  per-requester write (1) / read (0) select.
REQ-008 ADDR_IN  input  48  requester i address in bits [12*i+11:12*i].
REQ-009 D_IN  input  4*W  requester i write data in bits [W*i+W-1:W*i].
REQ-010 GNT  output  4  one-hot registered grant, owner index; all-zero in IDLE.
REQ-011 ACK  output  4  one-hot access-complete strobe, one cycle per access.
REQ-012 Q_OUT  output  W  read data, equals RAM_Q while any ACK high, else 0.
REQ-013 RAM_EN, RAM_WE  output  1 each  shared single-port RAM enable / write enable.
REQ-014 RAM_ADDR  output  12; RAM_D  output  W; RAM_Q  input  W (RAM registered output, 1-cycle read latency).
REQ-015 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; IDLE->ISSUE when any REQ high; ISSUE->RESP always; RESP->IDLE always.
REQ-017 In IDLE with any REQ, winner = first i with REQ[i] scanning PRI, PRI+1, ... mod 4; GNT and OWNER registered on that edge.
REQ-018 Lock priority: if LOCK[owner] was high in last RESP, REQ[owner] high in IDLE, and HOLD < MAXHOLD, the previous owner wins regardless of PRI.
REQ-019 HOLD counter: cleared on a non-lock grant, incremented on a lock grant; saturates at MAXHOLD; when HOLD = MAXHOLD the lock is ignored and round-robin applies.
REQ-020 PRI updates to (winner+1) mod 4 on every non-lock grant; unchanged on lock grants.
REQ-021 In ISSUE: RAM_EN=1, RAM_WE=WE_IN[owner], RAM_ADDR and RAM_D muxed from owner's slices; all four RAM outputs 0 outside ISSUE.
REQ-022 In RESP: ACK[owner]=1 combinationally from state, GNT unchanged; ACK issued for writes and reads alike.
REQ-023 Latency: REQ sampled high in IDLE at edge n -> RAM_EN in cycle n..n+1 -> ACK in cycle n+1..n+2; throughput one access per 3 cycles.
REQ-024 REQ dropped by a non-owner before grant: no access, no ACK; REQ of owner ignored after ISSUE (access completes).
REQ-025 Simultaneous requests from all four with PRI=0: grant order 0,1,2,3,0 under continuous request.
REQ-026 No combinational path from REQ/LOCK to GNT; ACK and Q_OUT depend only on state, OWNER, RAM_Q.

Reset
REQ-027 CLR high asynchronously forces state IDLE, GNT=0, OWNER=0, PRI=0, HOLD=0, lock flag=0; therefore ACK=0, Q_OUT=0, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_D=0, BUSY=0.
REQ-028 CLR during ISSUE or RESP aborts the access with no ACK; the first grant after CLR release uses PRI=0.

Structure
REQ-029 Shared constants package: state encodings (IDLE=2'b00, ISSUE=2'b01, RESP=2'b10), requester count 4, RAM address width 12.
REQ-030 One combinational sub-module rr_pick4: inputs REQ[3:0], PRI[1:0]; outputs winner index and valid.
REQ-031 Unused state 2'b11 SHALL transition to IDLE.

Verification
REQ-032 Single read: REQ=4'b0010, WE_IN=0, ADDR_IN slice1=12'h0A5, RAM returns 8'h3C -> GNT=4'b0010 one cycle after request, RAM_EN one cycle, ACK[1] and Q_OUT=8'h3C two cycles after request.
REQ-033 Fairness: REQ=4'b1111 held, no LOCK -> ACK sequence 0,1,2,3,0 at 3-cycle spacing.
REQ-034 Lock: requester 2 with LOCK=1, REQ=4'b0101 held, MAXHOLD=4 -> grants 0, then 2 repeatedly: total 5 consecutive grants to 2 (one initial + 4 locked), then 0.
REQ-035 Write: requester 3, WE_IN=1, ADDR 12'hFFF, D 8'h81 -> RAM_EN=RAM_WE=1, RAM_ADDR=12'hFFF, RAM_D=8'h81 for exactly one cycle, ACK[3] next cycle.
REQ-036 Reset mid-access: assert CLR in ISSUE -> all outputs 0 immediately, no ACK; after release with REQ=4'b1000, PRI=0 scan grants 3.
